// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
//   32-entry (2**L) x N-bit register file for the core's operand path.
//   Two combinational read ports, one synchronous write port. Register 0 is
//   hardwired to zero. The write address is decoded through an L-level binary
//   tree of 1-to-2 decoders whose root enable is wr_ena, so exactly one leaf
//   enable is high when wr_ena=1 and none otherwise.
//
// Ports
//   clk       in   1  clock, all state changes on the rising edge
//   rst       in   1  synchronous active-high reset, clears every register
//   wr_ena    in   1  write enable, root of the decode tree
//   wr_addr   in   L  write register index
//   wr_data   in   N  write data, stored unmodified
//   rd_addr0  in   L  read port 0 index
//   rd_data0  out  N  read port 0 data (combinational)
//   rd_addr1  in   L  read port 1 index
//   rd_data1  out  N  read port 1 data (combinational)
// ----------------------------------------------------------------------------

// One node of the write-address decode tree.
module dec_1to2 (
    input  logic       ena,
    input  logic       in,
    output logic [1:0] out
);
    assign out[0] = ena & ~in;
    assign out[1] = ena &  in;
endmodule

module register_file #(
    parameter int N = 32,
    parameter int L = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  logic [L-1:0] wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [L-1:0] rd_addr0,
    output logic [N-1:0] rd_data0,
    input  logic [L-1:0] rd_addr1,
    output logic [N-1:0] rd_data1
);
    localparam int DEPTH = 2 ** L;

    logic [N-1:0]     regs_q [DEPTH];
    logic [N-1:0]     regs_d [DEPTH];
    logic [DEPTH-1:0] wr_onehot;

    // Decode tree: level lv holds 2**lv nodes and consumes address bit
    // L-1-lv (MSB first), so the leaf position equals the binary address.
    for (genvar lv = 0; lv < L; lv++) begin : gen_lvl
        logic [2**(lv+1)-1:0] en;
        for (genvar p = 0; p < 2**lv; p++) begin : gen_node
            logic parent;
            if (lv == 0) begin : gen_root
                assign parent = wr_ena;
            end else begin : gen_inner
                assign parent = gen_lvl[lv-1].en[p];
            end
            dec_1to2 u_dec (
                .ena (parent),
                .in  (wr_addr[L-1-lv]),
                .out (en[2*p +: 2])
            );
        end
    end

    assign wr_onehot = gen_lvl[L-1].en;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_onehot[i]) begin
                regs_d[i] = wr_data;
            end
        end
        // Entry 0 never holds anything but zero, even when addressed.
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads see the stored value only; a same-cycle write is not forwarded.
    always_comb begin
        rd_data0 = (rd_addr0 == '0) ? '0 : regs_q[rd_addr0];
        rd_data1 = (rd_addr1 == '0) ? '0 : regs_q[rd_addr1];
    end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [31:0] rd_data0;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file #(.N(32), .L(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (rd_addr0),
        .rd_data0 (rd_data0),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        chk;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra0, input logic [4:0] ra1);
        rst      = r;
        wr_ena   = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_addr0 = ra0;
        rd_addr1 = ra1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle both ports over every address and compare with expected contents.
    task automatic sweep(input string name, input logic [31:0] exp_val [32]);
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
            check({name, "_p0"}, rd_data0, exp_val[a]);
            check({name, "_p1"}, rd_data1, exp_val[31 - a]);
        end
    endtask

    logic [31:0] exp_arr [32];
    logic [31:0] model   [32];

    initial begin
        // Pre-edge read expectations reflect state before each vector's edge.
        vecs[0]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd0,  1'b0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b1, 5'd3,  32'h12345678, 5'd5, 5'd0,  1'b1, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd3, 5'd31, 1'b1, 32'h12345678, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd3, 5'd31, 1'b1, 32'h12345678, 32'hCAFEF00D};
        vecs[4]  = '{1'b0, 1'b0, 5'd7,  32'hAAAA5555, 5'd0, 5'd31, 1'b1, 32'h0,        32'hCAFEF00D};
        vecs[5]  = '{1'b0, 1'b1, 5'd9,  32'h00000001, 5'd7, 5'd3,  1'b1, 32'h0,        32'h12345678};
        vecs[6]  = '{1'b0, 1'b1, 5'd9,  32'h00000002, 5'd9, 5'd9,  1'b1, 32'h1,        32'h1};
        vecs[7]  = '{1'b0, 1'b0, 5'd9,  32'h0,        5'd9, 5'd9,  1'b1, 32'h2,        32'h2};
        vecs[8]  = '{1'b1, 1'b1, 5'd2,  32'h00000055, 5'd3, 5'd31, 1'b1, 32'h12345678, 32'hCAFEF00D};
        vecs[9]  = '{1'b0, 1'b1, 5'd2,  32'h00000077, 5'd3, 5'd31, 1'b1, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd2, 5'd9,  1'b1, 32'h77,       32'h0};

        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        for (int v = 0; v < 11; v++) begin
            drive(vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra0, vecs[v].ra1);
            if (vecs[v].chk) begin
                check($sformatf("vec%0d_p0", v), rd_data0, vecs[v].e0);
                check($sformatf("vec%0d_p1", v), rd_data1, vecs[v].e1);
            end
            tick();
        end

        // Reset with a competing write to reg 5, then every address reads 0.
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        tick();
        for (int a = 0; a < 32; a++) exp_arr[a] = 32'h0;
        sweep("rst_sweep", exp_arr);

        // Write k to reg k: each leaf of the decode reaches only its own entry.
        for (int k = 1; k < 32; k++) begin
            drive(1'b0, 1'b1, 5'(k), 32'(k), 5'd0, 5'd0);
            tick();
        end
        for (int a = 0; a < 32; a++) exp_arr[a] = 32'(a);
        sweep("onehot_sweep", exp_arr);

        // Writing x0 must not disturb x0 nor any other entry.
        drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        tick();
        sweep("x0_sweep", exp_arr);

        // Disabled write leaves the target untouched.
        drive(1'b0, 1'b0, 5'd7, 32'hAAAA5555, 5'd7, 5'd7);
        tick();
        check("gated_wr", rd_data0, 32'd7);

        // Mid-stream reset: fill 1..4, reset with a write, then write again.
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 1'b1, 5'(k), 32'h100 + 32'(k), 5'd0, 5'd0);
            tick();
        end
        drive(1'b1, 1'b1, 5'd2, 32'h55, 5'd2, 5'd4);
        check("pre_rst_p0", rd_data0, 32'h102);
        check("pre_rst_p1", rd_data1, 32'h104);
        tick();
        for (int a = 0; a < 32; a++) exp_arr[a] = 32'h0;
        sweep("midrst_sweep", exp_arr);
        drive(1'b0, 1'b1, 5'd2, 32'h77, 5'd2, 5'd2);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd2);
        check("post_rst_wr_p0", rd_data0, 32'h77);
        check("post_rst_wr_p1", rd_data1, 32'h77);

        // Randomized traffic against an array model of the architectural state.
        for (int a = 0; a < 32; a++) model[a] = 32'h0;
        model[2] = 32'h77;
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst;
            logic        r_we;
            logic [4:0]  r_wa;
            logic [31:0] r_wd;
            logic [4:0]  r_ra0;
            logic [4:0]  r_ra1;
            r_rst = ($urandom_range(0, 99) == 0);
            r_we  = ($urandom_range(0, 3) != 0);
            r_wa  = 5'($urandom_range(0, 31));
            r_wd  = $urandom;
            r_ra0 = 5'($urandom_range(0, 31));
            r_ra1 = ($urandom_range(0, 3) == 0) ? r_ra0 : 5'($urandom_range(0, 31));
            drive(r_rst, r_we, r_wa, r_wd, r_ra0, r_ra1);
            check("rand_p0", rd_data0, (r_ra0 == 0) ? 32'h0 : model[r_ra0]);
            check("rand_p1", rd_data1, (r_ra1 == 0) ? 32'h0 : model[r_ra1]);
            tick();
            if (r_rst) begin
                for (int a = 0; a < 32; a++) model[a] = 32'h0;
            end else if (r_we && r_wa != 0) begin
                model[r_wa] = r_wd;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
